// File: rtl/wb_result_arbiter_pkg.sv
// Shared widths, channel indices and the buffered result entry
// for the writeback result arbiter.
package wb_result_arbiter_pkg;

    localparam int WB_ADDR_W  = 5;
    localparam int WB_DATA_W  = 32;
    localparam int WB_ENTRY_W = WB_ADDR_W + WB_DATA_W;

    localparam int NUM_CH = 3;
    localparam int CH_M   = 0;
    localparam int CH_X   = 1;
    localparam int CH_Y   = 2;

    typedef struct packed {
        logic [WB_ADDR_W-1:0] regdest;
        logic [WB_DATA_W-1:0] wbvalue;
    } wb_entry_t;

endpackage

// File: rtl/wb_channel_fifo.sv
// Per-unit result FIFO; an empty FIFO forwards a same-cycle
// push straight to pop_data so a lone result costs no extra cycle.
module wb_channel_fifo
    import wb_result_arbiter_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic                   push,
    input  wb_entry_t              push_data,
    input  logic                   pop,
    output wb_entry_t              pop_data,
    output logic                   empty,
    output logic                   full,
    output logic [$clog2(DEPTH):0] count
);

    localparam int AW = $clog2(DEPTH);

    wb_entry_t      mem [DEPTH];
    logic [AW-1:0]  wr_ptr;
    logic [AW-1:0]  rd_ptr;
    logic           push_ok;

    assign empty    = (count == '0);
    assign full     = (count == (AW+1)'(DEPTH));
    // A full FIFO still accepts a push when its head leaves this cycle.
    assign push_ok  = push && (!full || pop);
    assign pop_data = empty ? push_data : mem[rd_ptr];

    always_ff @(posedge clock) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push_ok) begin
                mem[wr_ptr] <= push_data;
                wr_ptr      <= wr_ptr + AW'(1);
            end
            if (pop)
                rd_ptr <= rd_ptr + AW'(1);
            if (push_ok && !pop)
                count <= count + (AW+1)'(1);
            else if (!push_ok && pop)
                count <= count - (AW+1)'(1);
        end
    end

endmodule

// File: rtl/wb_result_arbiter.sv
// Merges X/Y/M execute results into the single register-file
// write port: per-unit FIFOs, fixed M>X>Y select, registered output.
module wb_result_arbiter
    import wb_result_arbiter_pkg::*;
#(
    parameter int DEPTH        = 4,
    parameter int STALL_THRESH = 2
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic                 x_wb_writereg,
    input  logic [WB_ADDR_W-1:0] x_wb_regdest,
    input  logic [WB_DATA_W-1:0] x_wb_wbvalue,
    input  logic                 y_wb_writereg,
    input  logic [WB_ADDR_W-1:0] y_wb_regdest,
    input  logic [WB_DATA_W-1:0] y_wb_wbvalue,
    input  logic                 m_wb_writereg,
    input  logic [WB_ADDR_W-1:0] m_wb_regdest,
    input  logic [WB_DATA_W-1:0] m_wb_wbvalue,
    output logic                 ex_wb_writereg,
    output logic [WB_ADDR_W-1:0] ex_wb_regdest,
    output logic [WB_DATA_W-1:0] ex_wb_wbvalue,
    output logic                 wb_is_stall,
    output logic                 wb_overflow
);

    localparam int CW = $clog2(DEPTH) + 1;

    logic [NUM_CH-1:0]          push;
    logic [NUM_CH-1:0]          pop;
    logic [NUM_CH-1:0]          empty;
    logic [NUM_CH-1:0]          full;
    logic [NUM_CH-1:0]          avail;
    logic [NUM_CH-1:0][CW-1:0]  count;
    wb_entry_t [NUM_CH-1:0]     push_data;
    wb_entry_t [NUM_CH-1:0]     pop_data;
    wb_entry_t                  sel;
    logic                       any;
    logic                       drop;

    // Writes to $0 are discarded at the door.
    assign push[CH_M] = m_wb_writereg && (m_wb_regdest != '0);
    assign push[CH_X] = x_wb_writereg && (x_wb_regdest != '0);
    assign push[CH_Y] = y_wb_writereg && (y_wb_regdest != '0);

    assign push_data[CH_M] = '{regdest: m_wb_regdest, wbvalue: m_wb_wbvalue};
    assign push_data[CH_X] = '{regdest: x_wb_regdest, wbvalue: x_wb_wbvalue};
    assign push_data[CH_Y] = '{regdest: y_wb_regdest, wbvalue: y_wb_wbvalue};

    for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
        wb_channel_fifo #(.DEPTH(DEPTH)) u_fifo (
            .clock     (clock),
            .reset     (reset),
            .push      (push[c]),
            .push_data (push_data[c]),
            .pop       (pop[c]),
            .pop_data  (pop_data[c]),
            .empty     (empty[c]),
            .full      (full[c]),
            .count     (count[c])
        );
    end

    // An arriving result counts as present so it can bypass an empty FIFO.
    assign avail = ~empty | push;
    assign any   = |avail;

    always_comb begin
        pop = '0;
        sel = '0;
        if (avail[CH_M]) begin
            pop[CH_M] = 1'b1;
            sel       = pop_data[CH_M];
        end else if (avail[CH_X]) begin
            pop[CH_X] = 1'b1;
            sel       = pop_data[CH_X];
        end else if (avail[CH_Y]) begin
            pop[CH_Y] = 1'b1;
            sel       = pop_data[CH_Y];
        end
    end

    always_comb begin
        wb_is_stall = 1'b0;
        for (int c = 0; c < NUM_CH; c++)
            if (count[c] >= CW'(STALL_THRESH))
                wb_is_stall = 1'b1;
    end

    assign drop = |(push & full & ~pop);

    always_ff @(posedge clock) begin
        if (reset) begin
            ex_wb_writereg <= 1'b0;
            ex_wb_regdest  <= '0;
            ex_wb_wbvalue  <= '0;
            wb_overflow    <= 1'b0;
        end else begin
            ex_wb_writereg <= any;
            if (any) begin
                ex_wb_regdest <= sel.regdest;
                ex_wb_wbvalue <= sel.wbvalue;
            end
            if (drop)
                wb_overflow <= 1'b1;
        end
    end

endmodule

// File: tb/tb_wb_result_arbiter.sv
// Directed self-checking bench for wb_result_arbiter.
// Inputs change and outputs are sampled 1ns after each rising edge.
module tb_wb_result_arbiter;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        x_wb_writereg = 1'b0;
    logic [4:0]  x_wb_regdest = '0;
    logic [31:0] x_wb_wbvalue = '0;
    logic        y_wb_writereg = 1'b0;
    logic [4:0]  y_wb_regdest = '0;
    logic [31:0] y_wb_wbvalue = '0;
    logic        m_wb_writereg = 1'b0;
    logic [4:0]  m_wb_regdest = '0;
    logic [31:0] m_wb_wbvalue = '0;
    logic        ex_wb_writereg;
    logic [4:0]  ex_wb_regdest;
    logic [31:0] ex_wb_wbvalue;
    logic        wb_is_stall;
    logic        wb_overflow;

    int checks = 0;
    int errors = 0;

    wb_result_arbiter #(.DEPTH(4), .STALL_THRESH(2)) dut (
        .clock          (clock),
        .reset          (reset),
        .x_wb_writereg  (x_wb_writereg),
        .x_wb_regdest   (x_wb_regdest),
        .x_wb_wbvalue   (x_wb_wbvalue),
        .y_wb_writereg  (y_wb_writereg),
        .y_wb_regdest   (y_wb_regdest),
        .y_wb_wbvalue   (y_wb_wbvalue),
        .m_wb_writereg  (m_wb_writereg),
        .m_wb_regdest   (m_wb_regdest),
        .m_wb_wbvalue   (m_wb_wbvalue),
        .ex_wb_writereg (ex_wb_writereg),
        .ex_wb_regdest  (ex_wb_regdest),
        .ex_wb_wbvalue  (ex_wb_wbvalue),
        .wb_is_stall    (wb_is_stall),
        .wb_overflow    (wb_overflow)
    );

    always #5 clock = ~clock;

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic clear_in();
        x_wb_writereg = 0; x_wb_regdest = 0; x_wb_wbvalue = 0;
        y_wb_writereg = 0; y_wb_regdest = 0; y_wb_wbvalue = 0;
        m_wb_writereg = 0; m_wb_regdest = 0; m_wb_wbvalue = 0;
    endtask

    task automatic test_reset();
        clear_in();
        reset = 1;
        step();
        step();
        reset = 0;
        checks++;
        if ({ex_wb_writereg, ex_wb_regdest, ex_wb_wbvalue} !== 38'd0) begin
            errors++;
            $display("FAIL reset_out: got we=%0b rd=%0d val=%h want 0/0/0",
                     ex_wb_writereg, ex_wb_regdest, ex_wb_wbvalue);
        end
        checks++;
        if ({wb_is_stall, wb_overflow} !== 2'b00) begin
            errors++;
            $display("FAIL reset_flags: got stall=%0b ovf=%0b want 0/0",
                     wb_is_stall, wb_overflow);
        end
    endtask

    task automatic test_single();
        x_wb_writereg = 1; x_wb_regdest = 3; x_wb_wbvalue = 32'h11;
        step();
        clear_in();
        checks++;
        if (ex_wb_writereg !== 1'b1 || ex_wb_regdest !== 5'd3 || ex_wb_wbvalue !== 32'h11) begin
            errors++;
            $display("FAIL single_out: got we=%0b rd=%0d val=%h want 1/3/11",
                     ex_wb_writereg, ex_wb_regdest, ex_wb_wbvalue);
        end
        step();
        checks++;
        if (ex_wb_writereg !== 1'b0) begin
            errors++;
            $display("FAIL single_idle: got we=%0b want 0", ex_wb_writereg);
        end
        checks++;
        if (ex_wb_regdest !== 5'd3 || ex_wb_wbvalue !== 32'h11) begin
            errors++;
            $display("FAIL single_hold: got rd=%0d val=%h want 3/11",
                     ex_wb_regdest, ex_wb_wbvalue);
        end
    endtask

    task automatic test_triple();
        logic [4:0]  exp_rd [3] = '{5'd5, 5'd6, 5'd7};
        logic [31:0] exp_v  [3] = '{32'hA, 32'hB, 32'hC};
        m_wb_writereg = 1; m_wb_regdest = 5; m_wb_wbvalue = 32'hA;
        x_wb_writereg = 1; x_wb_regdest = 6; x_wb_wbvalue = 32'hB;
        y_wb_writereg = 1; y_wb_regdest = 7; y_wb_wbvalue = 32'hC;
        step();
        clear_in();
        for (int i = 0; i < 3; i++) begin
            checks++;
            if (ex_wb_writereg !== 1'b1 || ex_wb_regdest !== exp_rd[i] ||
                ex_wb_wbvalue !== exp_v[i]) begin
                errors++;
                $display("FAIL triple_%0d: got we=%0b rd=%0d val=%h want 1/%0d/%h", i,
                         ex_wb_writereg, ex_wb_regdest, ex_wb_wbvalue, exp_rd[i], exp_v[i]);
            end
            step();
        end
        checks++;
        if (ex_wb_writereg !== 1'b0) begin
            errors++;
            $display("FAIL triple_idle: got we=%0b want 0", ex_wb_writereg);
        end
    endtask

    task automatic test_drop();
        x_wb_writereg = 0; x_wb_regdest = 4; x_wb_wbvalue = 32'h44;
        m_wb_writereg = 1; m_wb_regdest = 0; m_wb_wbvalue = 32'hFF;
        step();
        clear_in();
        for (int i = 0; i < 3; i++) begin
            checks++;
            if (ex_wb_writereg !== 1'b0) begin
                errors++;
                $display("FAIL drop_%0d: got we=%0b want 0", i, ex_wb_writereg);
            end
            step();
        end
    endtask

    task automatic test_stall_overflow();
        for (int k = 0; k < 5; k++) begin
            m_wb_writereg = 1; m_wb_regdest = 1; m_wb_wbvalue = 32'h100 + k;
            x_wb_writereg = 1; x_wb_regdest = 8; x_wb_wbvalue = 32'h200 + k;
            step();
            checks++;
            if (ex_wb_writereg !== 1'b1 || ex_wb_regdest !== 5'd1 ||
                ex_wb_wbvalue !== 32'h100 + k) begin
                errors++;
                $display("FAIL stall_m_%0d: got we=%0b rd=%0d val=%h want 1/1/%h", k,
                         ex_wb_writereg, ex_wb_regdest, ex_wb_wbvalue, 32'h100 + k);
            end
            checks++;
            if (wb_is_stall !== (k >= 1)) begin
                errors++;
                $display("FAIL stall_%0d: got %0b want %0b", k, wb_is_stall, k >= 1);
            end
            checks++;
            if (wb_overflow !== (k == 4)) begin
                errors++;
                $display("FAIL ovf_%0d: got %0b want %0b", k, wb_overflow, k == 4);
            end
        end
        clear_in();
        for (int i = 0; i < 4; i++) begin
            step();
            checks++;
            if (ex_wb_writereg !== 1'b1 || ex_wb_regdest !== 5'd8 ||
                ex_wb_wbvalue !== 32'h200 + i) begin
                errors++;
                $display("FAIL drain_%0d: got we=%0b rd=%0d val=%h want 1/8/%h", i,
                         ex_wb_writereg, ex_wb_regdest, ex_wb_wbvalue, 32'h200 + i);
            end
        end
        step();
        checks++;
        if (ex_wb_writereg !== 1'b0 || wb_is_stall !== 1'b0) begin
            errors++;
            $display("FAIL drain_idle: got we=%0b stall=%0b want 0/0",
                     ex_wb_writereg, wb_is_stall);
        end
        checks++;
        if (wb_overflow !== 1'b1) begin
            errors++;
            $display("FAIL ovf_sticky: got %0b want 1", wb_overflow);
        end
    endtask

    task automatic test_reset_mid();
        m_wb_writereg = 1; m_wb_regdest = 5; m_wb_wbvalue = 32'h51;
        x_wb_writereg = 1; x_wb_regdest = 6; x_wb_wbvalue = 32'h61;
        y_wb_writereg = 1; y_wb_regdest = 7; y_wb_wbvalue = 32'h71;
        step();
        y_wb_writereg = 0;
        m_wb_wbvalue = 32'h52;
        x_wb_wbvalue = 32'h62;
        step();
        clear_in();
        checks++;
        if (wb_is_stall !== 1'b1) begin
            errors++;
            $display("FAIL mid_prestall: got %0b want 1", wb_is_stall);
        end
        reset = 1;
        step();
        reset = 0;
        checks++;
        if ({ex_wb_writereg, ex_wb_regdest, ex_wb_wbvalue} !== 38'd0 ||
            wb_is_stall !== 1'b0 || wb_overflow !== 1'b0) begin
            errors++;
            $display("FAIL mid_reset: got we=%0b rd=%0d val=%h stall=%0b ovf=%0b want all 0",
                     ex_wb_writereg, ex_wb_regdest, ex_wb_wbvalue, wb_is_stall, wb_overflow);
        end
        for (int i = 0; i < 4; i++) begin
            step();
            checks++;
            if (ex_wb_writereg !== 1'b0) begin
                errors++;
                $display("FAIL mid_stale_%0d: got we=%0b rd=%0d want we=0",
                         i, ex_wb_writereg, ex_wb_regdest);
            end
        end
    endtask

    task automatic test_full_push_pop();
        for (int k = 0; k < 4; k++) begin
            m_wb_writereg = 1; m_wb_regdest = 2; m_wb_wbvalue = 32'h300 + k;
            y_wb_writereg = 1; y_wb_regdest = 9; y_wb_wbvalue = 32'h400 + k;
            step();
        end
        m_wb_writereg = 0;
        y_wb_wbvalue = 32'h404;
        step();
        clear_in();
        checks++;
        if (ex_wb_writereg !== 1'b1 || ex_wb_regdest !== 5'd9 || ex_wb_wbvalue !== 32'h400) begin
            errors++;
            $display("FAIL full_head: got we=%0b rd=%0d val=%h want 1/9/400",
                     ex_wb_writereg, ex_wb_regdest, ex_wb_wbvalue);
        end
        checks++;
        if (wb_overflow !== 1'b0 || wb_is_stall !== 1'b1) begin
            errors++;
            $display("FAIL full_flags: got ovf=%0b stall=%0b want 0/1",
                     wb_overflow, wb_is_stall);
        end
        for (int i = 1; i <= 4; i++) begin
            step();
            checks++;
            if (ex_wb_writereg !== 1'b1 || ex_wb_regdest !== 5'd9 ||
                ex_wb_wbvalue !== 32'h400 + i) begin
                errors++;
                $display("FAIL full_drain_%0d: got we=%0b rd=%0d val=%h want 1/9/%h", i,
                         ex_wb_writereg, ex_wb_regdest, ex_wb_wbvalue, 32'h400 + i);
            end
        end
        step();
        checks++;
        if (ex_wb_writereg !== 1'b0 || wb_overflow !== 1'b0) begin
            errors++;
            $display("FAIL full_idle: got we=%0b ovf=%0b want 0/0",
                     ex_wb_writereg, wb_overflow);
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_triple();
        test_drop();
        test_stall_overflow();
        test_reset_mid();
        test_full_push_pop();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
